// File: rtl/div_issue_ctrl_pkg.sv
// Shared width and FSM state encoding for the DIV/DIVU issue controller.
package div_issue_ctrl_pkg;

    localparam int DATA_WIDTH = 32;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        DONE  = 3'd3,
        DRAIN = 3'd4
    } state_t;

endpackage

// File: rtl/div_issue_ctrl_hilo_regs.sv
// Architectural HI/LO registers. A divider writeback always beats a
// simultaneous move-to-HI/LO.
module hilo_regs
    import div_issue_ctrl_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             wb_en,
    input  logic [WIDTH-1:0] wb_hi,
    input  logic [WIDTH-1:0] wb_lo,
    input  logic             mthi_en,
    input  logic             mtlo_en,
    input  logic [WIDTH-1:0] mt_wdata,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hi <= '0;
            lo <= '0;
        end else if (wb_en) begin
            hi <= wb_hi;
            lo <= wb_lo;
        end else begin
            if (mthi_en) hi <= mt_wdata;
            if (mtlo_en) lo <= mt_wdata;
        end
    end

endmodule

// File: rtl/div_issue_ctrl.sv
// Issue controller between the EX stage and a multi-cycle divider: latches
// operands, pulses div_en once, stalls EX and writes HI/LO on completion.
module div_issue_ctrl #(
    parameter int DATA_WIDTH = div_issue_ctrl_pkg::DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  req_valid,
    input  logic                  req_signed,
    input  logic [DATA_WIDTH-1:0] req_src_a,
    input  logic [DATA_WIDTH-1:0] req_src_b,
    input  logic                  ex_flush,
    input  logic                  mthi,
    input  logic                  mtlo,
    input  logic [DATA_WIDTH-1:0] mt_wdata,
    output logic                  stall,
    output logic [DATA_WIDTH-1:0] hi,
    output logic [DATA_WIDTH-1:0] lo,
    output logic                  div_en,
    output logic                  div_signed,
    output logic [DATA_WIDTH-1:0] div_dividend,
    output logic [DATA_WIDTH-1:0] div_divisor,
    input  logic                  div_busy,
    input  logic                  div_complete,
    input  logic [DATA_WIDTH-1:0] div_quotient,
    input  logic [DATA_WIDTH-1:0] div_remainder
);

    import div_issue_ctrl_pkg::*;

    state_t                state;
    state_t                state_next;
    logic                  op_signed;
    logic [DATA_WIDTH-1:0] op_a;
    logic [DATA_WIDTH-1:0] op_b;
    logic                  accept;
    logic                  wb_en;
    logic                  stall_fsm;
    logic                  div_en_fsm;
    logic                  mt_allowed;
    logic                  unused_busy;

    // Completion is tracked through div_complete alone.
    assign unused_busy = div_busy;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            op_signed <= 1'b0;
            op_a      <= '0;
            op_b      <= '0;
        end else if (accept) begin
            op_signed <= req_signed;
            op_a      <= req_src_a;
            op_b      <= req_src_b;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        wb_en      = 1'b0;
        stall_fsm  = 1'b0;
        div_en_fsm = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid && !ex_flush) begin
                    accept     = 1'b1;
                    stall_fsm  = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                div_en_fsm = 1'b1;
                stall_fsm  = 1'b1;
                state_next = ex_flush ? DRAIN : WAIT;
            end
            WAIT: begin
                stall_fsm = 1'b1;
                // A flush that lands with the result drops it; nothing left to drain.
                if (div_complete) begin
                    wb_en      = !ex_flush;
                    state_next = ex_flush ? IDLE : DONE;
                end else if (ex_flush) begin
                    state_next = DRAIN;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            DRAIN: begin
                stall_fsm = req_valid;
                if (div_complete) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Reset must silence the outputs at once, even while req_valid is high.
    assign stall      = stall_fsm & resetn;
    assign div_en     = div_en_fsm & resetn;
    assign mt_allowed = (state == IDLE) && !stall_fsm && !ex_flush;

    assign div_signed   = op_signed;
    assign div_dividend = op_a;
    assign div_divisor  = op_b;

    hilo_regs #(
        .WIDTH(DATA_WIDTH)
    ) u_hilo_regs (
        .clk      (clk),
        .resetn   (resetn),
        .wb_en    (wb_en),
        .wb_hi    (div_remainder),
        .wb_lo    (div_quotient),
        .mthi_en  (mthi && mt_allowed),
        .mtlo_en  (mtlo && mt_allowed),
        .mt_wdata (mt_wdata),
        .hi       (hi),
        .lo       (lo)
    );

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Directed bench for div_issue_ctrl with a 33-cycle divider stub.
module tb_div_issue_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic        req_valid;
    logic        req_signed;
    logic [31:0] req_src_a;
    logic [31:0] req_src_b;
    logic        ex_flush;
    logic        mthi;
    logic        mtlo;
    logic [31:0] mt_wdata;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div_en;
    logic        div_signed;
    logic [31:0] div_dividend;
    logic [31:0] div_divisor;
    logic        div_busy;
    logic        div_complete;
    logic [31:0] div_quotient;
    logic [31:0] div_remainder;

    int checks = 0;
    int errors = 0;

    int          div_cnt;
    logic [31:0] model_q;
    logic [31:0] model_r;

    always #5 clk = ~clk;

    div_issue_ctrl #(.DATA_WIDTH(32)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .req_valid     (req_valid),
        .req_signed    (req_signed),
        .req_src_a     (req_src_a),
        .req_src_b     (req_src_b),
        .ex_flush      (ex_flush),
        .mthi          (mthi),
        .mtlo          (mtlo),
        .mt_wdata      (mt_wdata),
        .stall         (stall),
        .hi            (hi),
        .lo            (lo),
        .div_en        (div_en),
        .div_signed    (div_signed),
        .div_dividend  (div_dividend),
        .div_divisor   (div_divisor),
        .div_busy      (div_busy),
        .div_complete  (div_complete),
        .div_quotient  (div_quotient),
        .div_remainder (div_remainder)
    );

    // Divider stub: divide-by-zero returns all-ones quotient and the dividend.
    function automatic logic [63:0] divide(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q;
        logic [31:0] r;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (sgn) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    // Result appears 33 cycles after the div_en cycle; junk when not complete.
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            div_cnt <= 0;
            model_q <= '0;
            model_r <= '0;
        end else if (div_en) begin
            div_cnt            <= 33;
            {model_r, model_q} <= divide(div_signed, div_dividend, div_divisor);
        end else if (div_cnt != 0) begin
            div_cnt <= div_cnt - 1;
        end
    end

    assign div_complete  = (div_cnt == 1);
    assign div_busy      = (div_cnt != 0);
    assign div_quotient  = div_complete ? model_q : 32'hBAD0_BAD0;
    assign div_remainder = div_complete ? model_r : 32'hBAD0_BAD0;

    task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    // One full division with the instruction held in EX until DONE.
    task automatic run_div(input string tag, input logic sgn, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_lo, input logic [31:0] exp_hi);
        int en = 0;
        int bad = 0;
        int unstable = 0;
        for (int c = 0; c <= 35; c++) begin
            req_valid  = (c <= 34);
            req_signed = sgn;
            req_src_a  = a;
            req_src_b  = b;
            #1;
            if (stall !== (c <= 34)) bad++;
            if (div_en) en++;
            if (c >= 1 && c <= 34 && (div_dividend !== a || div_divisor !== b || div_signed !== sgn)) unstable++;
            if (c == 35) begin
                check_output({tag, "_lo"}, lo, exp_lo);
                check_output({tag, "_hi"}, hi, exp_hi);
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        check_output({tag, "_div_en_pulses"}, 32'(en), 32'd1);
        check_output({tag, "_stall_bad_cycles"}, 32'(bad), 32'd0);
        check_output({tag, "_operand_unstable"}, 32'(unstable), 32'd0);
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int en_first = 0;
        int en_all = 0;
        for (int c = 0; c <= 72; c++) begin
            req_valid = (c <= 70);
            if (c < 35) begin
                req_signed = 1'b0; req_src_a = 32'd100;  req_src_b = 32'd7;
            end else begin
                req_signed = 1'b1; req_src_a = 32'd1000; req_src_b = 32'd10;
            end
            #1;
            if (div_en) en_all++;
            if (div_en && c <= 36) en_first++;
            if (c == 35) begin
                check_output("b2b_first_lo", lo, 32'h0000_000E);
                check_output("b2b_first_hi", hi, 32'h0000_0002);
                check_output("b2b_done_stall", 32'(stall), 32'd0);
            end
            if (c == 36) check_output("b2b_accept_stall", 32'(stall), 32'd1);
            if (c == 37) begin
                check_output("b2b_second_div_en", 32'(div_en), 32'd1);
                check_output("b2b_second_dividend", div_dividend, 32'h0000_03E8);
                check_output("b2b_second_signed", 32'(div_signed), 32'd1);
            end
            if (c == 71) begin
                check_output("b2b_second_lo", lo, 32'h0000_0064);
                check_output("b2b_second_hi", hi, 32'h0000_0000);
                check_output("b2b_second_done_stall", 32'(stall), 32'd0);
            end
            @(negedge clk);
        end
        check_output("b2b_first_issue_count", 32'(en_first), 32'd1);
        check_output("b2b_total_issue_count", 32'(en_all), 32'd2);
    endtask

    task automatic test_flush();
        int en_drain = 0;
        for (int c = 0; c <= 71; c++) begin
            req_valid = (c < 10) || (c >= 21 && c <= 69);
            if (c < 21) begin
                req_signed = 1'b0; req_src_a = 32'h0000_1000; req_src_b = 32'h0000_0010;
            end else begin
                req_signed = 1'b0; req_src_a = 32'd53; req_src_b = 32'd5;
            end
            ex_flush = (c == 10);
            #1;
            if (div_en && c >= 2 && c <= 35) en_drain++;
            if (c == 10) check_output("flush_wait_stall", 32'(stall), 32'd1);
            if (c == 15) check_output("flush_drain_idle_stall", 32'(stall), 32'd0);
            if (c == 25) check_output("flush_drain_req_stall", 32'(stall), 32'd1);
            if (c == 35) begin
                check_output("flush_hi_kept", hi, 32'h0000_0005);
                check_output("flush_lo_kept", lo, 32'hFFFF_FFFF);
                check_output("flush_accept_stall", 32'(stall), 32'd1);
            end
            if (c == 36) begin
                check_output("flush_next_div_en", 32'(div_en), 32'd1);
                check_output("flush_next_dividend", div_dividend, 32'd53);
            end
            if (c == 70) begin
                check_output("flush_next_lo", lo, 32'h0000_000A);
                check_output("flush_next_hi", hi, 32'h0000_0003);
                check_output("flush_next_done_stall", 32'(stall), 32'd0);
            end
            @(negedge clk);
        end
        ex_flush = 1'b0;
        check_output("flush_no_issue_in_drain", 32'(en_drain), 32'd0);
    endtask

    task automatic test_mt();
        mthi = 1'b1; mt_wdata = 32'h1234_5678;
        @(negedge clk);
        mthi = 1'b0;
        #1;
        check_output("mthi_idle_hi", hi, 32'h1234_5678);
        check_output("mthi_idle_lo_kept", lo, 32'h0000_000A);
        @(negedge clk);
        mtlo = 1'b1; ex_flush = 1'b1; mt_wdata = 32'h5555_5555;
        @(negedge clk);
        mtlo = 1'b0; ex_flush = 1'b0;
        #1;
        check_output("mtlo_flush_ignored", lo, 32'h0000_000A);
        @(negedge clk);
        for (int c = 0; c <= 36; c++) begin
            req_valid  = (c <= 34);
            req_signed = 1'b0; req_src_a = 32'd20; req_src_b = 32'd6;
            mtlo       = (c == 0) || (c == 10);
            mt_wdata   = 32'hDEAD_BEEF;
            #1;
            if (c == 1) check_output("mtlo_accept_ignored", lo, 32'h0000_000A);
            if (c == 11) begin
                check_output("mtlo_wait_ignored", lo, 32'h0000_000A);
                check_output("mthi_held_in_wait", hi, 32'h1234_5678);
            end
            if (c == 35) begin
                check_output("mt_div_lo", lo, 32'h0000_0003);
                check_output("mt_div_hi", hi, 32'h0000_0002);
            end
            @(negedge clk);
        end
        mtlo = 1'b0;
    endtask

    task automatic test_reset_mid();
        for (int c = 0; c <= 20; c++) begin
            req_valid  = 1'b1;
            req_signed = 1'b1; req_src_a = 32'hFFFF_FF9C; req_src_b = 32'd7;
            if (c == 20) resetn = 1'b0;
            #1;
            if (c == 19) check_output("reset_mid_wait_stall", 32'(stall), 32'd1);
            if (c == 20) begin
                check_output("reset_mid_hi", hi, 32'h0000_0000);
                check_output("reset_mid_lo", lo, 32'h0000_0000);
                check_output("reset_mid_stall", 32'(stall), 32'd0);
                check_output("reset_mid_div_en", 32'(div_en), 32'd0);
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        #1;
        check_output("reset_release_stall", 32'(stall), 32'd0);
        @(negedge clk);
        run_div("after_reset", 1'b1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE);
    endtask

    initial begin
        resetn     = 1'b0;
        req_valid  = 1'b0;
        req_signed = 1'b0;
        req_src_a  = '0;
        req_src_b  = '0;
        ex_flush   = 1'b0;
        mthi       = 1'b0;
        mtlo       = 1'b0;
        mt_wdata   = '0;
        #7;
        check_output("reset_hi", hi, 32'h0000_0000);
        check_output("reset_lo", lo, 32'h0000_0000);
        check_output("reset_stall", 32'(stall), 32'd0);
        check_output("reset_div_en", 32'(div_en), 32'd0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        run_div("div_signed", 1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        run_div("divu", 1'b0, 32'hFFFF_FFF9, 32'h0000_0002, 32'h7FFF_FFFC, 32'h0000_0001);
        test_back_to_back();
        run_div("div_by_zero", 1'b0, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0005);
        test_flush();
        test_mt();
        test_reset_mid();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/div_issue_ctrl.md
DIV_ISSUE_CTRL -- requirements
Module: div_issue_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 32, operand/result width.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 resetn  in  1  asynchronous, active-low reset.
REQ-004 req_valid  in  1  EX stage holds a DIV/DIVU instruction.
REQ-005 req_signed  in  1  1 = DIV, 0 = DIVU.
REQ-006 req_src_a / req_src_b  in  32  dividend / divisor from EX.
REQ-007 ex_flush  in  1  EX instruction cancelled (exception/eret).
REQ-008 mthi / mtlo / mt_wdata  in  1/1/32  move-to-HI/LO request and data.
REQ-009 stall  out  1  hold EX stage.
REQ-010 hi / lo  out  32  architectural HI (remainder) / LO (quotient).
REQ-011 div_en / div_signed / div_dividend / div_divisor  out  1/1/32/32  divider request.
REQ-012 div_busy / div_complete / div_quotient / div_remainder  in  1/1/32/32  divider response; results valid only while div_complete=1.

Function
REQ-013 FSM states SHALL be IDLE, ISSUE, WAIT, DONE, DRAIN.
REQ-014 IDLE: req_valid & !ex_flush -> latch req_signed/src_a/src_b into operand registers, go ISSUE; otherwise stay.
REQ-015 ISSUE: div_en=1 for exactly this one cycle, outputs driven from operand registers; go WAIT (ex_flush -> DRAIN).
REQ-016 div_en SHALL be 0 in every state other than ISSUE; div_dividend/div_divisor/div_signed SHALL stay stable from ISSUE until div_complete.
REQ-017 WAIT: div_complete -> hi<=div_remainder, lo<=div_quotient at that edge, go DONE; ex_flush (no complete) -> DRAIN; ex_flush and div_complete in same cycle -> no write, go IDLE.
REQ-018 DONE: lasts one cycle, stall=0, req_valid ignored (same instruction leaving EX), go IDLE.
REQ-019 DRAIN: wait for div_complete, discard result, no HI/LO write, then IDLE; new request not accepted before IDLE.
REQ-020 stall SHALL be 1 in IDLE when accepting a request, in ISSUE and WAIT; 1 in DRAIN only if req_valid; 0 otherwise.
REQ-021 Stall cycles SHALL equal (cycles from ISSUE to div_complete) + 2; with a divider completing 33 cycles after div_en, stall is high cycles 0-34 for a request seen in cycle 0, hi/lo visible in cycle 35.
REQ-022 mthi/mtlo SHALL write mt_wdata into hi/lo at the edge only in IDLE with stall=0 and !ex_flush; ignored in any other state.
REQ-023 Division writeback SHALL take priority over any simultaneous mthi/mtlo.
REQ-024 Divide-by-zero SHALL not be checked; hi/lo take whatever the divider returns; FSM terminates normally.
REQ-025 The controller SHALL never deassert stall before div_complete for an unflushed division.

Reset
REQ-026 resetn low SHALL immediately force state IDLE, hi=0, lo=0, operand registers=0, div_en=0, stall=0, regardless of state.
REQ-027 Reset mid-division SHALL discard the in-flight operation; the divider shares the same reset event.

Structure
REQ-028 Shared package SHALL hold DATA_WIDTH and the FSM state encoding constants.
REQ-029 HI/LO storage with MT/writeback priority SHALL be one sub-module, hilo_regs; FSM and operand latches stay in div_issue_ctrl.

Verification
REQ-030 DIV 0xFFFFFFF9 / 0x00000002 signed -> lo=0xFFFFFFFD, hi=0xFFFFFFFF in DONE; div_en exactly one pulse.
REQ-031 DIVU 0xFFFFFFF9 / 0x00000002 -> lo=0x7FFFFFFC, hi=0x00000001; stall high cycles 0-34 with 33-cycle divider model.
REQ-032 Back-to-back DIVs (req_valid held for next instruction right after DONE) -> second issue in cycle after DONE, no duplicate issue of first.
REQ-033 ex_flush in WAIT cycle 10 -> DRAIN, hi/lo unchanged at complete, next request issued only after IDLE.
REQ-034 mthi 0x12345678 in IDLE then mtlo during WAIT -> hi=0x12345678, mtlo ignored, lo=quotient after completion.
REQ-035 resetn low during WAIT cycle 20 -> hi=lo=0, stall=0, div_en=0 immediately; new DIV after release completes correctly.
